// File: rtl/arp_pkt_responder_pkg.sv
// ARP protocol constants, FSM state type and the per-offset request header check
// shared by the ARP responder.
package arp_pkg;

  typedef enum logic [1:0] {RX, CHECK, TX} state_t;

  localparam int ARP_PAYLOAD_LEN = 28;
  localparam int ARP_REPLY_LEN   = 42;

  localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;
  localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY = 16'h0002;

  localparam logic [4:0] OFF_HTYPE = 5'd0;
  localparam logic [4:0] OFF_PTYPE = 5'd2;
  localparam logic [4:0] OFF_HLEN  = 5'd4;
  localparam logic [4:0] OFF_PLEN  = 5'd5;
  localparam logic [4:0] OFF_OPER  = 5'd6;
  localparam logic [4:0] OFF_SHA   = 5'd8;
  localparam logic [4:0] OFF_SPA   = 5'd14;
  localparam logic [4:0] OFF_THA   = 5'd18;
  localparam logic [4:0] OFF_TPA   = 5'd24;

  typedef struct packed {
    logic       en;
    logic [7:0] val;
  } byte_chk_t;

  // Required value of a request byte at offset idx; en=0 where the byte is free.
  function automatic byte_chk_t rx_byte_check(input logic [4:0] idx, input logic [31:0] local_ip);
    byte_chk_t r;
    r.en  = 1'b1;
    r.val = 8'h00;
    case (idx)
      OFF_HTYPE:        r.val = ARP_HTYPE_ETH[15:8];
      OFF_HTYPE + 5'd1: r.val = ARP_HTYPE_ETH[7:0];
      OFF_PTYPE:        r.val = ARP_PTYPE_IPV4[15:8];
      OFF_PTYPE + 5'd1: r.val = ARP_PTYPE_IPV4[7:0];
      OFF_HLEN:         r.val = ARP_HLEN_ETH;
      OFF_PLEN:         r.val = ARP_PLEN_IPV4;
      OFF_OPER:         r.val = ARP_OPER_REQ[15:8];
      OFF_OPER + 5'd1:  r.val = ARP_OPER_REQ[7:0];
      OFF_TPA:          r.val = local_ip[31:24];
      OFF_TPA + 5'd1:   r.val = local_ip[23:16];
      OFF_TPA + 5'd2:   r.val = local_ip[15:8];
      OFF_TPA + 5'd3:   r.val = local_ip[7:0];
      default:          r.en  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arp_pkt_responder_if.sv
// Byte-stream handshakes of the ARP responder: request bytes in from the ARP FIFO,
// reply frame bytes out toward the MAC TX path.
interface arp_pkt_responder_if;
  logic [7:0] i_arp_pkt_byte;
  logic       i_arp_pkt_byte_vld;
  logic       i_arp_pkt_last_byte;
  logic       o_arp_pkt_byte_rd;
  logic [7:0] o_arp_reply_byte;
  logic       o_arp_reply_vld;
  logic       o_arp_reply_last;
  logic       i_arp_reply_rd;
  logic       o_arp_reply_sent;
  logic       o_arp_pkt_dropped;

  modport master (
    input  i_arp_pkt_byte, i_arp_pkt_byte_vld, i_arp_pkt_last_byte, i_arp_reply_rd,
    output o_arp_pkt_byte_rd, o_arp_reply_byte, o_arp_reply_vld, o_arp_reply_last,
    output o_arp_reply_sent, o_arp_pkt_dropped
  );

  modport slave (
    output i_arp_pkt_byte, i_arp_pkt_byte_vld, i_arp_pkt_last_byte, i_arp_reply_rd,
    input  o_arp_pkt_byte_rd, o_arp_reply_byte, o_arp_reply_vld, o_arp_reply_last,
    input  o_arp_reply_sent, o_arp_pkt_dropped
  );
endinterface

// File: rtl/arp_pkt_responder.sv
// Answers IPv4-over-Ethernet ARP requests for the local IP with a 42-byte reply
// frame; anything else is drained to its last byte and flagged as dropped.
//   state | meaning
//   RX    | pop and check request bytes until last_byte
//   CHECK | accept (go TX) or pulse dropped
//   TX    | present reply frame bytes, one per consumer pop
module arp_pkt_responder
  import arp_pkg::*;
#(
  parameter logic [47:0] P_LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter logic [31:0] P_LOCAL_IP  = 32'hC0A8_0101
) (
  input logic                 i_rxmac_clk,
  input logic                 i_rxmac_arst,
  arp_pkt_responder_if.master arp
);

  localparam logic [4:0] RX_CNT_SAT  = 5'(ARP_PAYLOAD_LEN);
  localparam logic [5:0] TX_CNT_LAST = 6'(ARP_REPLY_LEN - 1);

  state_t    state, state_nxt;
  logic [4:0] rx_cnt;
  logic [5:0] tx_cnt;
  logic       bad;
  logic [47:0] sha;
  logic [31:0] spa;
  logic       rx_pop, tx_pop, pkt_ok;
  byte_chk_t  rx_chk;
  logic [0:ARP_REPLY_LEN-1][7:0] frame;

  assign rx_pop = (state == RX) && arp.i_arp_pkt_byte_vld;
  assign tx_pop = (state == TX) && arp.i_arp_reply_rd;
  assign pkt_ok = !bad && (rx_cnt == RX_CNT_SAT);
  assign rx_chk = rx_byte_check(rx_cnt, P_LOCAL_IP);

  // Reply frame in transmit order, element 0 goes out first.
  assign frame = {sha, P_LOCAL_MAC, ETH_TYPE_ARP, ARP_HTYPE_ETH, ARP_PTYPE_IPV4,
                  ARP_HLEN_ETH, ARP_PLEN_IPV4, ARP_OPER_REPLY, P_LOCAL_MAC, P_LOCAL_IP,
                  sha, spa};

  always_ff @(posedge i_rxmac_clk or posedge i_rxmac_arst) begin
    if (i_rxmac_arst) state <= RX;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX:      if (rx_pop && arp.i_arp_pkt_last_byte) state_nxt = CHECK;
      CHECK:   state_nxt = pkt_ok ? TX : RX;
      TX:      if (tx_pop && (tx_cnt == TX_CNT_LAST)) state_nxt = RX;
      default: state_nxt = RX;
    endcase
  end

  // RX is the reset state, so the pop strobe alone needs masking during reset.
  always_comb begin
    arp.o_arp_pkt_byte_rd = 1'b0;
    arp.o_arp_reply_byte  = 8'h00;
    arp.o_arp_reply_vld   = 1'b0;
    arp.o_arp_reply_last  = 1'b0;
    arp.o_arp_reply_sent  = 1'b0;
    arp.o_arp_pkt_dropped = 1'b0;
    case (state)
      RX:    arp.o_arp_pkt_byte_rd = arp.i_arp_pkt_byte_vld & ~i_rxmac_arst;
      CHECK: arp.o_arp_pkt_dropped = ~pkt_ok;
      TX: begin
        arp.o_arp_reply_vld  = 1'b1;
        arp.o_arp_reply_byte = frame[tx_cnt];
        arp.o_arp_reply_last = (tx_cnt == TX_CNT_LAST);
        arp.o_arp_reply_sent = (tx_cnt == TX_CNT_LAST) && arp.i_arp_reply_rd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_rxmac_clk or posedge i_rxmac_arst) begin
    if (i_rxmac_arst) begin
      rx_cnt <= '0;
      tx_cnt <= '0;
      bad    <= 1'b0;
      sha    <= '0;
      spa    <= '0;
    end else begin
      case (state)
        RX: if (rx_pop) begin
          if (rx_cnt != RX_CNT_SAT) rx_cnt <= rx_cnt + 5'd1;
          if (rx_chk.en && (rx_chk.val != arp.i_arp_pkt_byte)) bad <= 1'b1;
          if ((rx_cnt >= OFF_SHA) && (rx_cnt < OFF_SPA)) sha <= {sha[39:0], arp.i_arp_pkt_byte};
          if ((rx_cnt >= OFF_SPA) && (rx_cnt < OFF_THA)) spa <= {spa[23:0], arp.i_arp_pkt_byte};
        end
        CHECK: begin
          rx_cnt <= '0;
          bad    <= 1'b0;
        end
        TX: if (tx_pop) tx_cnt <= (tx_cnt == TX_CNT_LAST) ? 6'd0 : tx_cnt + 6'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_pkt_responder.sv
// Directed and randomized bench for arp_pkt_responder with a byte-level ARP
// reference model and cycle-accurate latency/handshake checks.
module tb_arp_pkt_responder;

  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
  localparam logic [31:0] LOCAL_IP  = 32'hC0A8_0101;

  typedef struct {
    logic [7:0] b;
    logic       last;
  } in_t;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  arp_pkt_responder_if ifc();

  arp_pkt_responder #(.P_LOCAL_MAC(LOCAL_MAC), .P_LOCAL_IP(LOCAL_IP)) dut (
    .i_rxmac_clk (clk),
    .i_rxmac_arst(arst),
    .arp         (ifc)
  );

  in_t        in_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pkt_buf[$];
  int  errors = 0, checks = 0, cyc = 0, last_pop = -100;
  int  drops_pending = 0, rep_idx = 0, reset_at = -1;
  bit  throttle = 0, gaps = 0, in_vld = 0;
  logic       prev_vld = 1'b0, prev_rd = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic put(input bit to_exp, input logic [63:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      if (to_exp) exp_q.push_back(8'(v >> (8 * k)));
      else        pkt_buf.push_back(8'(v >> (8 * k)));
    end
  endtask

  // Builds the request bytes, queues them for the source, and derives the expected
  // outcome straight from the byte stream: a reply frame or one drop.
  task automatic add_pkt(input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa,
                         input logic [15:0] oper, input int len, input int bad_idx);
    in_t e;
    bit  ok;
    pkt_buf.delete();
    put(0, 64'h0001, 2);
    put(0, 64'h0800, 2);
    put(0, 64'h06, 1);
    put(0, 64'h04, 1);
    put(0, 64'(oper), 2);
    put(0, 64'(sha), 6);
    put(0, 64'(spa), 4);
    put(0, {$urandom, $urandom}, 6);
    put(0, 64'(tpa), 4);
    while (pkt_buf.size() < len) pkt_buf.push_back(8'($urandom));
    while (pkt_buf.size() > len) void'(pkt_buf.pop_back());
    if (bad_idx >= 0 && bad_idx < len) pkt_buf[bad_idx] = pkt_buf[bad_idx] ^ 8'h5a;
    for (int i = 0; i < len; i++) begin
      e.b = pkt_buf[i];
      e.last = (i == len - 1);
      in_q.push_back(e);
    end
    ok = (len >= 28)
      && ({pkt_buf[0], pkt_buf[1]} == 16'h0001) && ({pkt_buf[2], pkt_buf[3]} == 16'h0800)
      && (pkt_buf[4] == 8'd6) && (pkt_buf[5] == 8'd4)
      && ({pkt_buf[6], pkt_buf[7]} == 16'h0001)
      && ({pkt_buf[24], pkt_buf[25], pkt_buf[26], pkt_buf[27]} == LOCAL_IP);
    if (ok) begin
      for (int i = 8; i < 14; i++) exp_q.push_back(pkt_buf[i]);
      put(1, 64'(LOCAL_MAC), 6);
      put(1, 64'h0806, 2);
      put(1, 64'h0001, 2);
      put(1, 64'h0800, 2);
      put(1, 64'h06, 1);
      put(1, 64'h04, 1);
      put(1, 64'h0002, 2);
      put(1, 64'(LOCAL_MAC), 6);
      put(1, 64'(LOCAL_IP), 4);
      for (int i = 8; i < 18; i++) exp_q.push_back(pkt_buf[i]);
    end else begin
      drops_pending++;
    end
  endtask

  task automatic cycle();
    logic exp_last, exp_sent;
    @(negedge clk);
    if (arst) arst = 1'b0;
    cyc++;
    in_vld = (in_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
    if (in_vld) begin
      ifc.i_arp_pkt_byte      = in_q[0].b;
      ifc.i_arp_pkt_last_byte = in_q[0].last;
    end else begin
      ifc.i_arp_pkt_byte      = 8'($urandom);
      ifc.i_arp_pkt_last_byte = 1'($urandom);
    end
    ifc.i_arp_pkt_byte_vld = in_vld;
    ifc.i_arp_reply_rd     = throttle ? 1'($urandom) : 1'b1;
    #1;
    if (reset_at >= 0 && ifc.o_arp_reply_vld && rep_idx == reset_at) begin
      arst = 1'b1;
      #1;
      chk("outputs_on_midreply_reset", 64'({ifc.o_arp_pkt_byte_rd, ifc.o_arp_reply_byte,
          ifc.o_arp_reply_vld, ifc.o_arp_reply_last, ifc.o_arp_reply_sent,
          ifc.o_arp_pkt_dropped}), 64'(0));
      exp_q.delete();
      rep_idx  = 0;
      reset_at = -1;
      prev_vld = 1'b0;
      prev_rd  = 1'b0;
      return;
    end
    if (ifc.o_arp_pkt_byte_rd) begin
      chk("pop_needs_vld", 64'(in_vld), 64'(1));
      chk("no_pop_during_reply", 64'(ifc.o_arp_reply_vld), 64'(0));
      if (in_vld) begin
        if (in_q[0].last) last_pop = cyc;
        void'(in_q.pop_front());
      end
    end
    exp_last = ifc.o_arp_reply_vld && (rep_idx == 41);
    exp_sent = exp_last && ifc.i_arp_reply_rd;
    chk("reply_last", 64'(ifc.o_arp_reply_last), 64'(exp_last));
    chk("reply_sent", 64'(ifc.o_arp_reply_sent), 64'(exp_sent));
    if (ifc.o_arp_reply_vld) begin
      chk("reply_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) chk("reply_byte", 64'(ifc.o_arp_reply_byte), 64'(exp_q[0]));
      if (!prev_vld) chk("reply_latency", 64'(cyc - last_pop), 64'(2));
      if (prev_vld && !prev_rd) chk("reply_stable", 64'(ifc.o_arp_reply_byte), 64'(prev_byte));
      if (ifc.i_arp_reply_rd) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (rep_idx == 41) begin
          if (!throttle) chk("sent_cycle", 64'(cyc - last_pop), 64'(43));
          rep_idx = 0;
        end else begin
          rep_idx++;
        end
      end
    end
    if (ifc.o_arp_pkt_dropped) begin
      chk("drop_expected", 64'(drops_pending > 0), 64'(1));
      chk("drop_cycle", 64'(cyc - last_pop), 64'(1));
      if (drops_pending > 0) drops_pending--;
    end
    prev_vld  = ifc.o_arp_reply_vld;
    prev_rd   = ifc.i_arp_reply_rd;
    prev_byte = ifc.o_arp_reply_byte;
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (n < budget && (in_q.size() != 0 || exp_q.size() != 0 || drops_pending != 0)) begin
      cycle();
      n++;
    end
    chk("run_completes", 64'(n < budget), 64'(1));
    repeat (4) cycle();
  endtask

  initial begin
    arst = 1'b1;
    ifc.i_arp_pkt_byte      = 8'h5a;
    ifc.i_arp_pkt_byte_vld  = 1'b1;
    ifc.i_arp_pkt_last_byte = 1'b1;
    ifc.i_arp_reply_rd      = 1'b1;
    #12;
    chk("outputs_in_reset", 64'({ifc.o_arp_pkt_byte_rd, ifc.o_arp_reply_byte,
        ifc.o_arp_reply_vld, ifc.o_arp_reply_last, ifc.o_arp_reply_sent,
        ifc.o_arp_pkt_dropped}), 64'(0));
    ifc.i_arp_pkt_byte_vld = 1'b0;
    @(negedge clk);
    arst = 1'b0;

    // valid request, reply consumer always ready
    add_pkt(48'h00_11_22_33_44_55, 32'hC0A8_0132, LOCAL_IP, 16'h0001, 28, -1);
    chk("model_first_byte", 64'(exp_q[0]), 64'h00);
    chk("model_last_byte", 64'(exp_q[41]), 64'h32);
    run(200);

    // request for another host
    add_pkt(48'h00_11_22_33_44_55, 32'hC0A8_0132, 32'hC0A8_0102, 16'h0001, 28, -1);
    run(200);

    // truncated packet, then a normal request
    add_pkt(48'h00_11_22_33_44_55, 32'hC0A8_0132, LOCAL_IP, 16'h0001, 20, -1);
    add_pkt(48'h00_11_22_33_44_55, 32'hC0A8_0132, LOCAL_IP, 16'h0001, 28, -1);
    run(300);

    // padded request
    add_pkt(48'h00_11_22_33_44_55, 32'hC0A8_0132, LOCAL_IP, 16'h0001, 46, -1);
    run(300);

    // throttled consumer with a second request queued, gappy source
    throttle = 1;
    gaps = 1;
    add_pkt(48'hAA_BB_CC_DD_EE_01, 32'h0A00_0001, LOCAL_IP, 16'h0001, 28, -1);
    add_pkt(48'h12_34_56_78_9A_BC, 32'h0A00_0002, LOCAL_IP, 16'h0001, 34, -1);
    run(1000);

    // reset while reply byte 20 is presented
    throttle = 0;
    gaps = 0;
    reset_at = 20;
    add_pkt(48'h00_11_22_33_44_55, 32'hC0A8_0132, LOCAL_IP, 16'h0001, 28, -1);
    run(200);
    chk("midreply_reset_taken", 64'(reset_at), 64'(-1));
    add_pkt(48'h66_77_88_99_AA_BB, 32'hC0A8_0140, LOCAL_IP, 16'h0001, 28, -1);
    run(200);

    // randomized mix
    throttle = 1;
    gaps = 1;
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < 3; p++) begin
        add_pkt({$urandom, 16'($urandom)}, $urandom,
                ($urandom_range(0, 3) == 0) ? $urandom : LOCAL_IP,
                ($urandom_range(0, 5) == 0) ? 16'h0002 : 16'h0001,
                $urandom_range(18, 50),
                ($urandom_range(0, 1) == 0) ? $urandom_range(0, 49) : -1);
      end
      run(2000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
